axi_sram_slave: RTL and testbench

- AXI4 responder (slave) backed by an on-chip synchronous RAM.
- Terminates the 64-bit AXI4 master port of the core top-level. Used as boot/scratch memory in simulation and FPGA builds.
- Independent read and write engines. One outstanding transaction per direction.
- Supports FIXED and INCR bursts up to 256 beats.

---
 rtl/axi_sram_slave_if.sv | 48 ++++
 rtl/axi_sram_slave.sv | 207 ++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_slave_if.sv
// AXI4 64-bit bus bundle between the core master port and the SRAM responder.
interface axi_sram_slave_if;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 responder over a 64-bit synchronous RAM; independent single-outstanding
// read and write engines, FIXED/INCR bursts up to 256 beats.
module axi_sram_slave #(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic               clock,
  input  logic               reset,
  axi_sram_slave_if.slave    SAXI
);
  localparam int          IDX_W     = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 8);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} r_state_e;

  function automatic logic in_range(input logic [31:0] a);
    return (a - BASE_ADDR) < MEM_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 3);
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + (32'd1 << size);
  endfunction

  logic [63:0] mem [MEM_WORDS];
  logic [63:0] rd_hold_q;

  // ---------------- write engine ----------------
  w_state_e    w_state_q, w_state_d;
  logic [3:0]  aw_id_q, aw_id_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic [7:0]  aw_len_q, aw_len_d;
  logic [2:0]  aw_size_q, aw_size_d;
  logic [1:0]  aw_burst_q, aw_burst_d;
  logic [7:0]  w_cnt_q, w_cnt_d;
  logic        w_err_q, w_err_d;
  logic        awready_c, wready_c, bvalid_c, mem_we;

  always_comb begin
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_cnt_d    = w_cnt_q;
    w_err_d    = w_err_q;
    awready_c  = 1'b0;
    wready_c   = 1'b0;
    bvalid_c   = 1'b0;
    mem_we     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready_c = 1'b1;
        if (SAXI.awvalid) begin
          aw_id_d    = SAXI.awid;
          aw_addr_d  = SAXI.awaddr;
          aw_len_d   = SAXI.awlen;
          aw_size_d  = SAXI.awsize;
          aw_burst_d = SAXI.awburst;
          w_cnt_d    = 8'd0;
          w_err_d    = 1'b0;
          w_state_d  = W_DATA;
        end
      end
      W_DATA: begin
        wready_c = 1'b1;
        if (SAXI.wvalid) begin
          mem_we = in_range(aw_addr_q) & ~reset;
          // The beat counter terminates the burst; a disagreeing wlast only flags an error.
          if (!in_range(aw_addr_q) || (SAXI.wlast != (w_cnt_q == aw_len_q))) w_err_d = 1'b1;
          if (w_cnt_q == aw_len_q) begin
            w_state_d = W_RESP;
          end else begin
            w_cnt_d   = w_cnt_q + 8'd1;
            aw_addr_d = next_addr(aw_addr_q, aw_size_q, aw_burst_q);
          end
        end
      end
      W_RESP: begin
        bvalid_c = 1'b1;
        if (SAXI.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // ---------------- read engine ----------------
  r_state_e    r_state_q, r_state_d;
  logic [3:0]  ar_id_q, ar_id_d;
  logic [31:0] ar_addr_q, ar_addr_d;
  logic [7:0]  ar_len_q, ar_len_d;
  logic [2:0]  ar_size_q, ar_size_d;
  logic [1:0]  ar_burst_q, ar_burst_d;
  logic [7:0]  r_cnt_q, r_cnt_d;
  logic        arready_c, rvalid_c, rd_en;

  always_comb begin
    r_state_d  = r_state_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    r_cnt_d    = r_cnt_q;
    arready_c  = 1'b0;
    rvalid_c   = 1'b0;
    rd_en      = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready_c = 1'b1;
        if (SAXI.arvalid) begin
          ar_id_d    = SAXI.arid;
          ar_addr_d  = SAXI.araddr;
          ar_len_d   = SAXI.arlen;
          ar_size_d  = SAXI.arsize;
          ar_burst_d = SAXI.arburst;
          r_cnt_d    = 8'd0;
          r_state_d  = R_READ;
        end
      end
      R_READ: begin
        rd_en     = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        rvalid_c = 1'b1;
        if (SAXI.rready) begin
          if (r_cnt_q == ar_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d   = r_cnt_q + 8'd1;
            ar_addr_d = next_addr(ar_addr_q, ar_size_q, ar_burst_q);
            r_state_d = R_READ;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q  <= W_IDLE;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
      r_state_q  <= R_IDLE;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_cnt_q    <= '0;
    end else begin
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_cnt_q    <= w_cnt_d;
      w_err_q    <= w_err_d;
      r_state_q  <= r_state_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      r_cnt_q    <= r_cnt_d;
    end
  end

  // RAM contents survive reset; non-blocking update gives read-first on a same-word collision.
  always_ff @(posedge clock) begin
    if (mem_we)
      for (int b = 0; b < 8; b++)
        if (SAXI.wstrb[b]) mem[word_idx(aw_addr_q)][b*8 +: 8] <= SAXI.wdata[b*8 +: 8];
    if (rd_en) rd_hold_q <= mem[word_idx(ar_addr_q)];
  end

  logic bv, rv, r_oor;
  assign bv    = bvalid_c & ~reset;
  assign rv    = rvalid_c & ~reset;
  assign r_oor = ~in_range(ar_addr_q);

  assign SAXI.awready = awready_c & ~reset;
  assign SAXI.wready  = wready_c & ~reset;
  assign SAXI.bvalid  = bv;
  assign SAXI.bresp   = (bv && w_err_q) ? 2'b10 : 2'b00;
  assign SAXI.bid     = reset ? 4'd0 : aw_id_q;
  assign SAXI.arready = arready_c & ~reset;
  assign SAXI.rvalid  = rv;
  assign SAXI.rdata   = (rv && !r_oor) ? rd_hold_q : 64'd0;
  assign SAXI.rresp   = (rv && r_oor) ? 2'b10 : 2'b00;
  assign SAXI.rlast   = rv & (r_cnt_q == ar_len_q);
  assign SAXI.rid     = reset ? 4'd0 : ar_id_q;
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: single-beat vector table plus burst,
// backpressure, concurrency, wlast-error and reset-abort sequences.
module tb_axi_sram_slave;
  logic clock = 1'b0;
  logic reset = 1'b1;
  axi_sram_slave_if saxi();

  axi_sram_slave dut (.clock(clock), .reset(reset), .SAXI(saxi));

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic [3:0]  rd_id;
  int          rd_lat, rd_nlast, rd_last_idx, rd_stable_err;
  time         rd_t, wr_t;
  logic [1:0]  wr_resp;
  logic [3:0]  wr_bid;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  id;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  exp_resp;
    logic [63:0] exp_data;
  } vec_t;
  vec_t vt [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [63:0] d0, input logic [7:0] strb_all,
                           input int alt_beat, input logic [7:0] strb_alt, input int last_beat);
    int g;
    g = 0;
    saxi.awid = id; saxi.awaddr = addr; saxi.awlen = len; saxi.awsize = 3'd3;
    saxi.awburst = burst; saxi.awvalid = 1'b1;
    while (!saxi.awready && g < 50) begin @(posedge clock); #1; g++; end
    if (g >= 50) tmo("aw_handshake");
    wr_t = $time;
    @(posedge clock); #1;
    saxi.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      saxi.wdata  = d0 + 64'(i);
      saxi.wstrb  = (i == alt_beat) ? strb_alt : strb_all;
      saxi.wlast  = (i == last_beat);
      saxi.wvalid = 1'b1;
      g = 0;
      while (!saxi.wready && g < 50) begin @(posedge clock); #1; g++; end
      if (g >= 50) tmo("w_beat");
      @(posedge clock); #1;
    end
    saxi.wvalid = 1'b0;
    saxi.wlast  = 1'b0;
    g = 0;
    while (!saxi.bvalid && g < 50) begin @(posedge clock); #1; g++; end
    if (g >= 50) tmo("b_response");
    wr_resp = saxi.bresp;
    wr_bid  = saxi.bid;
    saxi.bready = 1'b1;
    @(posedge clock); #1;
    saxi.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input bit toggle);
    int g, lat, beat;
    bit ph, stalled;
    logic [63:0] prev;
    g = 0;
    saxi.arid = id; saxi.araddr = addr; saxi.arlen = len; saxi.arsize = 3'd3;
    saxi.arburst = burst; saxi.arvalid = 1'b1;
    while (!saxi.arready && g < 50) begin @(posedge clock); #1; g++; end
    if (g >= 50) tmo("ar_handshake");
    rd_t = $time;
    @(posedge clock); #1;
    saxi.arvalid = 1'b0;
    lat = 1; beat = 0; ph = 1'b1; stalled = 1'b0; prev = '0;
    rd_lat = -1; rd_nlast = 0; rd_last_idx = -1; rd_stable_err = 0;
    while (beat <= int'(len) && lat < 200) begin
      if (saxi.rvalid) begin
        if (rd_lat < 0) rd_lat = lat;
        if (stalled && saxi.rdata !== prev) rd_stable_err++;
        saxi.rready = toggle ? ph : 1'b1;
        ph = ~ph;
        if (saxi.rready) begin
          rd_data[beat] = saxi.rdata;
          rd_resp[beat] = saxi.rresp;
          rd_id = saxi.rid;
          if (saxi.rlast) begin rd_nlast++; rd_last_idx = beat; end
          beat++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev = saxi.rdata;
        end
      end else begin
        saxi.rready = 1'b0;
      end
      @(posedge clock); #1;
      lat++;
    end
    saxi.rready = 1'b0;
    if (beat <= int'(len)) tmo("r_burst");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g, beats;
    saxi.awvalid = 0; saxi.wvalid = 0; saxi.bready = 0; saxi.arvalid = 0; saxi.rready = 0;
    saxi.awid = 0; saxi.awaddr = 0; saxi.awlen = 0; saxi.awsize = 0; saxi.awburst = 0;
    saxi.wdata = 0; saxi.wstrb = 0; saxi.wlast = 0;
    saxi.arid = 0; saxi.araddr = 0; saxi.arlen = 0; saxi.arsize = 0; saxi.arburst = 0;

    vt[0] = '{1'b1, 32'h8000_0010, 4'h3, 64'h1122334455667788, 8'hFF, 2'b00, 64'h0};
    vt[1] = '{1'b0, 32'h8000_0010, 4'h5, 64'h0, 8'h00, 2'b00, 64'h1122334455667788};
    vt[2] = '{1'b1, 32'h8000_0018, 4'h1, 64'hDEADBEEF_CAFEF00D, 8'hFF, 2'b00, 64'h0};
    vt[3] = '{1'b1, 32'h8000_0018, 4'h2, 64'h01234567_89ABCDEF, 8'hF0, 2'b00, 64'h0};
    vt[4] = '{1'b0, 32'h8000_0018, 4'h6, 64'h0, 8'h00, 2'b00, 64'h01234567_CAFEF00D};
    vt[5] = '{1'b1, 32'h8000_7FF8, 4'h7, 64'h5555666677778888, 8'hFF, 2'b00, 64'h0};
    vt[6] = '{1'b1, 32'h7FFF_FFF8, 4'h8, 64'hBAD0BAD0BAD0BAD0, 8'hFF, 2'b10, 64'h0};
    vt[7] = '{1'b0, 32'h8000_7FF8, 4'h9, 64'h0, 8'h00, 2'b00, 64'h5555666677778888};
    vt[8] = '{1'b0, 32'h8000_8000, 4'hA, 64'h0, 8'h00, 2'b10, 64'h0};
    vt[9] = '{1'b1, 32'h8000_8000, 4'hB, 64'h0123, 8'hFF, 2'b10, 64'h0};

    // reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_awready", 64'(saxi.awready), 64'd0);
    chk("rst_arready", 64'(saxi.arready), 64'd0);
    chk("rst_bvalid", 64'(saxi.bvalid), 64'd0);
    chk("rst_rvalid", 64'(saxi.rvalid), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("post_rst_awready", 64'(saxi.awready), 64'd1);
    chk("post_rst_arready", 64'(saxi.arready), 64'd1);

    // single-beat vector table
    for (int i = 0; i < 10; i++) begin
      if (vt[i].wr) begin
        axi_write(vt[i].id, vt[i].addr, 8'd0, 2'b01, vt[i].data, vt[i].strb, -1, 8'h00, 0);
        chk($sformatf("vec%0d_bresp", i), 64'(wr_resp), 64'(vt[i].exp_resp));
        chk($sformatf("vec%0d_bid", i), 64'(wr_bid), 64'(vt[i].id));
      end else begin
        axi_read(vt[i].id, vt[i].addr, 8'd0, 2'b01, 1'b0);
        chk($sformatf("vec%0d_rdata", i), rd_data[0], vt[i].exp_data);
        chk($sformatf("vec%0d_rresp", i), 64'(rd_resp[0]), 64'(vt[i].exp_resp));
        chk($sformatf("vec%0d_rid", i), 64'(rd_id), 64'(vt[i].id));
        chk($sformatf("vec%0d_latency", i), 64'(rd_lat), 64'd2);
        chk($sformatf("vec%0d_nlast", i), 64'(rd_nlast), 64'd1);
      end
    end

    // 4-beat INCR, then a strobe-masked overwrite touching only word 0x22 low half
    axi_write(4'h1, 32'h8000_0100, 8'd3, 2'b01, 64'hA5A5_0000_0000_0000, 8'hFF, -1, 8'h00, 3);
    chk("incr_fill_bresp", 64'(wr_resp), 64'd0);
    axi_write(4'h2, 32'h8000_0100, 8'd3, 2'b01, 64'h0000_0000_1234_5600, 8'h00, 2, 8'h0F, 3);
    chk("incr_strb_bresp", 64'(wr_resp), 64'd0);
    axi_read(4'h4, 32'h8000_0100, 8'd3, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("incr_rd%0d", i), rd_data[i],
          (i == 2) ? 64'hA5A5_0000_1234_5602 : 64'hA5A5_0000_0000_0000 + 64'(i));
    chk("incr_nlast", 64'(rd_nlast), 64'd1);
    chk("incr_last_idx", 64'(rd_last_idx), 64'd3);

    // 8-beat read under 1010 rready backpressure
    axi_write(4'h5, 32'h8000_0200, 8'd7, 2'b01, 64'hB000_0000_0000_0000, 8'hFF, -1, 8'h00, 7);
    axi_read(4'h6, 32'h8000_0200, 8'd7, 2'b01, 1'b1);
    for (int i = 0; i < 8; i++)
      chk($sformatf("bp_rd%0d", i), rd_data[i], 64'hB000_0000_0000_0000 + 64'(i));
    chk("bp_stable", 64'(rd_stable_err), 64'd0);
    chk("bp_nlast", 64'(rd_nlast), 64'd1);
    chk("bp_last_idx", 64'(rd_last_idx), 64'd7);

    // FIXED bursts stay on one word
    axi_write(4'h7, 32'h8000_0300, 8'd3, 2'b00, 64'hC000_0000_0000_0000, 8'hFF, -1, 8'h00, 3);
    axi_read(4'h8, 32'h8000_0300, 8'd2, 2'b00, 1'b0);
    chk("fixed_rd0", rd_data[0], 64'hC000_0000_0000_0003);
    chk("fixed_rd2", rd_data[2], 64'hC000_0000_0000_0003);

    // wlast early on beat 1 of len=3, and wlast never asserted
    axi_write(4'h9, 32'h8000_0400, 8'd3, 2'b01, 64'hD0, 8'hFF, -1, 8'h00, 1);
    chk("wlast_early_bresp", 64'(wr_resp), 64'd2);
    axi_write(4'hA, 32'h8000_0400, 8'd3, 2'b01, 64'hD0, 8'hFF, -1, 8'h00, -1);
    chk("wlast_missing_bresp", 64'(wr_resp), 64'd2);
    axi_write(4'hB, 32'h8000_0400, 8'd1, 2'b01, 64'hD0, 8'hFF, -1, 8'h00, 1);
    chk("wlast_clear_bresp", 64'(wr_resp), 64'd0);

    // simultaneous AW and AR
    chk("idle_awready", 64'(saxi.awready), 64'd1);
    chk("idle_arready", 64'(saxi.arready), 64'd1);
    fork
      axi_write(4'hC, 32'h8000_0500, 8'd0, 2'b01, 64'h7777, 8'hFF, -1, 8'h00, 0);
      axi_read(4'hD, 32'h8000_0010, 8'd0, 2'b01, 1'b0);
    join
    chk("conc_same_cycle", 64'(wr_t), 64'(rd_t));
    chk("conc_bresp", 64'(wr_resp), 64'd0);
    chk("conc_bid", 64'(wr_bid), 64'hC);
    chk("conc_rdata", rd_data[0], 64'h1122334455667788);
    chk("conc_rid", 64'(rd_id), 64'hD);
    axi_read(4'hE, 32'h8000_0500, 8'd0, 2'b01, 1'b0);
    chk("conc_wr_readback", rd_data[0], 64'h7777);

    // reset during beat 2 of a 4-beat read
    saxi.arid = 4'h1; saxi.araddr = 32'h8000_0100; saxi.arlen = 8'd3;
    saxi.arsize = 3'd3; saxi.arburst = 2'b01; saxi.arvalid = 1'b1;
    g = 0;
    while (!saxi.arready && g < 50) begin @(posedge clock); #1; g++; end
    @(posedge clock); #1;
    saxi.arvalid = 1'b0;
    saxi.rready  = 1'b1;
    beats = 0; g = 0;
    while (beats < 2 && g < 50) begin
      if (saxi.rvalid) beats++;
      @(posedge clock); #1; g++;
    end
    while (!saxi.rvalid && g < 50) begin @(posedge clock); #1; g++; end
    if (g >= 50) tmo("rst_mid_setup");
    saxi.rready = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_mid_rvalid", 64'(saxi.rvalid), 64'd0);
    chk("rst_mid_bvalid", 64'(saxi.bvalid), 64'd0);
    chk("rst_mid_rdata", saxi.rdata, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_mid_awready", 64'(saxi.awready), 64'd1);
    chk("rst_mid_arready", 64'(saxi.arready), 64'd1);
    chk("rst_mid_no_rvalid", 64'(saxi.rvalid), 64'd0);
    axi_write(4'h3, 32'h8000_0600, 8'd0, 2'b01, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, -1, 8'h00, 0);
    chk("rst_mid_new_bresp", 64'(wr_resp), 64'd0);
    axi_read(4'h2, 32'h8000_0600, 8'd0, 2'b01, 1'b0);
    chk("rst_mid_new_rdata", rd_data[0], 64'h0F0F_0F0F_0F0F_0F0F);
    chk("rst_mid_new_rid", 64'(rd_id), 64'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
